inst_fetch: RTL and testbench

Instruction fetch stage plus IF/ID pipeline register, directly upstream of the instruction decoder. Keeps the program counter and drives a synchronous instruction memory with a 1-cycle read latency. Presents a registered instruction/PC pair to decode, and absorbs stalls with a 1-entry skid buffer. Redirects come from two sources: JAL from decode (target computed here as PC + decoder immediate) and branch/JALR from execute.

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch.sv | 127 ++++++++++++
 tb/tb_inst_fetch.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch_if : bus between the fetch stage, its instruction memory, |
// | the hazard unit, decode and execute.           Revision: 1.0         |
// +----------------------------------------------------------------------+
interface inst_fetch_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        IF_stall;
  logic        ID_jmp_vld;
  logic [31:0] ID_imm;
  logic        EX_jmp_vld;
  logic [31:0] EX_jmp_addr;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
  logic        IF_vld;

  modport master (
    output imem_en, imem_addr, IF_inst, IF_pc, IF_vld,
    input  imem_rdata, IF_stall, ID_jmp_vld, ID_imm, EX_jmp_vld, EX_jmp_addr
  );

  modport slave (
    input  imem_en, imem_addr, IF_inst, IF_pc, IF_vld,
    output imem_rdata, IF_stall, ID_jmp_vld, ID_imm, EX_jmp_vld, EX_jmp_addr
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch : PC, 1-cycle-latency imem requests, IF/ID register and a |
// | 1-entry skid buffer that absorbs decode stalls.  Revision: 1.0       |
// +----------------------------------------------------------------------+
module inst_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.master bus
);

  localparam logic [31:0] PC_START = {PC_RESET[31:2], 2'b00};

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_vld_q, if_vld_d;

  logic        ex_redir;
  logic        jal_redir;
  logic        redir;
  logic        issue;
  logic [31:0] jal_sum;
  logic [31:0] redir_tgt;
  logic        unused_ok;

  always_comb begin
    jal_sum   = if_pc_q + bus.ID_imm;
    ex_redir  = bus.EX_jmp_vld;
    jal_redir = if_vld_q & bus.ID_jmp_vld & ~bus.IF_stall & ~bus.EX_jmp_vld;
    redir     = ex_redir | jal_redir;
    redir_tgt = ex_redir ? {bus.EX_jmp_addr[31:2], 2'b00} : {jal_sum[31:2], 2'b00};
    // Issue only while the skid/response pair still has a free slot to land in.
    issue     = ~bus.IF_stall | (~skid_vld_q & ~rsp_vld_q);
  end

  assign bus.imem_en   = ~rst & (redir | issue);
  assign bus.imem_addr = rst ? PC_START : (redir ? redir_tgt : fetch_pc_q);
  assign bus.IF_inst   = if_inst_q;
  assign bus.IF_pc     = if_pc_q;
  assign bus.IF_vld    = if_vld_q;
  assign unused_ok     = ^{bus.EX_jmp_addr[1:0], jal_sum[1:0]};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_pc_d    = rsp_pc_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    if_vld_d    = if_vld_q;

    if (redir) begin
      // The response in flight belongs to the wrong path and is dropped.
      fetch_pc_d = redir_tgt + 32'd4;
      rsp_vld_d  = 1'b1;
      rsp_pc_d   = redir_tgt;
      skid_vld_d = 1'b0;
      if_vld_d   = 1'b0;
      if_inst_d  = NOP_INST;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        rsp_vld_d  = 1'b1;
        rsp_pc_d   = fetch_pc_q;
      end else begin
        rsp_vld_d = 1'b0;
      end

      if (!bus.IF_stall) begin
        if (skid_vld_q) begin
          if_inst_d  = skid_inst_q;
          if_pc_d    = skid_pc_q;
          if_vld_d   = 1'b1;
          skid_vld_d = 1'b0;
        end else if (rsp_vld_q) begin
          if_inst_d = bus.imem_rdata;
          if_pc_d   = rsp_pc_q;
          if_vld_d  = 1'b1;
        end else begin
          if_inst_d = NOP_INST;
          if_vld_d  = 1'b0;
        end
      end else if (rsp_vld_q && !skid_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_inst_d = bus.imem_rdata;
        skid_pc_d   = rsp_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= PC_START;
      rsp_vld_q   <= 1'b0;
      rsp_pc_q    <= 32'd0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= 32'd0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= 32'd0;
      if_vld_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_pc_q    <= rsp_pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      if_vld_q    <= if_vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_fetch : program-order scoreboard bench for inst_fetch.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_inst_fetch;
  localparam logic [31:0] PC_RST = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if ifc ();

  inst_fetch #(.PC_RESET(PC_RST), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected program order of instructions decode will accept.
  logic [31:0] exp_q[$];
  logic        exp_redir = 1'b0;
  logic [31:0] exp_tgt   = 32'd0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h0001_0203;
  endfunction

  always @(posedge clk) begin
    if (ifc.imem_en) ifc.imem_rdata <= mem_f(ifc.imem_addr);
    else             ifc.imem_rdata <= $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (caller sits just after posedge) and update the model.
  task automatic apply(input logic r, input logic st, input logic jv, input logic [31:0] imm,
                       input logic ev, input logic [31:0] ea);
    logic [31:0] t;
    logic [31:0] head;
    rst             = r;
    ifc.IF_stall    = st;
    ifc.ID_jmp_vld  = jv;
    ifc.ID_imm      = imm;
    ifc.EX_jmp_vld  = ev;
    ifc.EX_jmp_addr = ea;
    exp_redir       = 1'b0;
    if (r) begin
      exp_q.delete();
      exp_q.push_back(PC_RST);
    end else if (ev) begin
      t = ea & ~32'h3;
      exp_q.delete();
      exp_q.push_back(t);
      exp_redir = 1'b1;
      exp_tgt   = t;
    end else if (jv && (ifc.IF_vld === 1'b1) && !st) begin
      head = exp_q[0];
      t    = (head + imm) & ~32'h3;
      exp_q.delete();
      exp_q.push_back(head);
      exp_q.push_back(t);
      exp_redir = 1'b1;
      exp_tgt   = t;
    end
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic cyc(input logic r, input logic st, input logic jv, input logic [31:0] imm,
                     input logic ev, input logic [31:0] ea);
    @(posedge clk);
    #1;
    apply(r, st, jv, imm, ev, ea);
  endtask

  // Monitor: checks every cycle at negedge and retires accepted instructions.
  initial begin
    logic        rst_prev;
    int          bub;
    logic [31:0] got;
    rst_prev = 1'b0;
    bub      = 0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        chk("rst_if_vld", {31'd0, ifc.IF_vld}, 32'd0);
        chk("rst_if_inst", ifc.IF_inst, NOP);
        chk("rst_if_pc", ifc.IF_pc, 32'd0);
      end
      if (rst) begin
        chk("rst_imem_en", {31'd0, ifc.imem_en}, 32'd0);
        chk("rst_imem_addr", ifc.imem_addr, PC_RST);
        bub = 0;
      end else begin
        chk("addr_align", {30'd0, ifc.imem_addr[1:0]}, 32'd0);
        if (!ifc.IF_stall) chk("issue_en", {31'd0, ifc.imem_en}, 32'd1);
        if (exp_redir) begin
          chk("redir_en", {31'd0, ifc.imem_en}, 32'd1);
          chk("redir_addr", ifc.imem_addr, exp_tgt);
        end
        chk("skid_rsp_excl", {31'd0, dut.skid_vld_q & dut.rsp_vld_q}, 32'd0);
        if (ifc.IF_vld) chk("inst_data", ifc.IF_inst, mem_f(ifc.IF_pc));
        else            chk("bubble_nop", ifc.IF_inst, NOP);
        if (ifc.IF_vld && !ifc.IF_stall && !ifc.EX_jmp_vld) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pc_order actual=%h expected=<none>", ifc.IF_pc);
          end else begin
            got = exp_q.pop_front();
            chk("pc_order", ifc.IF_pc, got);
          end
          bub = 0;
        end else if (ifc.EX_jmp_vld) begin
          bub = 0;
        end else if (!ifc.IF_stall) begin
          bub++;
          checks++;
          if (bub > 2) begin
            errors++;
            $display("FAIL max_bubbles actual=%0d required<=2 t=%0t", bub, $time);
          end
        end
      end
      rst_prev = rst;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic        r, st, jv, ev;
    logic [31:0] imm;
    apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Reset release: request at T, IF_vld at T+2, imem_addr two ahead of IF_pc.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("t0_imem_en", {31'd0, ifc.imem_en}, 32'd1);
    chk("t0_imem_addr", ifc.imem_addr, PC_RST);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("t2_if_vld", {31'd0, ifc.IF_vld}, 32'd1);
    chk("t2_if_pc", ifc.IF_pc, PC_RST);
    chk("t2_addr_lead", ifc.imem_addr, PC_RST + 32'd8);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // JAL at 0x200 with offset 0x40.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ifc.IF_vld === 1'b1 && ifc.IF_pc === 32'h200) begin
        apply(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        found = 1'b1;
      end else begin
        apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      end
    end
    chk("jal_reach_200", {31'd0, found}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("jal_bubble", {31'd0, ifc.IF_vld}, 32'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Three-cycle stall while streaming.
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // EX redirect to an unaligned target while stalled, skid full.
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h1003);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("ex_squash_vld", {31'd0, ifc.IF_vld}, 32'd0);
    chk("ex_squash_inst", ifc.IF_inst, NOP);
    chk("ex_skid_clear", {31'd0, dut.skid_vld_q}, 32'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // JAL and EX redirect in the same cycle: EX target only.
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h800);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Reset pulsed in the middle of a stall.
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 2) == 0);
      ev  = !r && ($urandom_range(0, 11) == 0);
      jv  = !r && ((ifc.IF_vld === 1'b1) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 19) == 0));
      imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      apply(r, st, jv, imm, ev, $urandom);
    end
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
